// File: rtl/issue_ctrl.sv
// Issue controller between the decoder and the execute-stage register.
// Tracks pending loads, stalls on load-use/WAW hazards, serialises branches and traps on illegal codes.
module issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rs1i,
  input  logic [4:0]       dec_rs2i,
  input  logic [4:0]       dec_rdi,
  input  logic [31:0]      dec_imm,
  input  logic [11:0]      dec_code,
  input  logic             dec_isLoad,
  input  logic             dec_isBranch,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [4:0]       ex_rs1i,
  output logic [4:0]       ex_rs2i,
  output logic [4:0]       ex_rdi,
  output logic [31:0]      ex_imm,
  output logic [11:0]      ex_code,
  output logic             ex_isLoad,
  output logic             ex_isBranch,
  input  logic             ld_done,
  input  logic [4:0]       ld_rd,
  input  logic             br_resolved,
  input  logic             br_taken,
  output logic             flush,
  output logic             trap,
  output logic [31:0]      sb_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_BR = 2'd1,
    TRAP    = 2'd2
  } state_t;

  state_t      state, state_d;
  logic        flush_d;
  logic [31:0] sb_d;
  logic        illegal;
  logic        hazard;
  logic        slot_free;
  logic        issue;
  logic        stall;

  // Hazards look only at the registered scoreboard; a same-cycle ld_done does not unblock.
  assign illegal   = (dec_code == 12'hFFF) || (dec_code == 12'h001);
  assign hazard    = ((dec_rs1i != 5'd0) && sb_busy[dec_rs1i]) ||
                     ((dec_rs2i != 5'd0) && sb_busy[dec_rs2i]) ||
                     ((dec_rdi  != 5'd0) && sb_busy[dec_rdi]);
  assign slot_free = !ex_valid || ex_ready;
  assign dec_ready = (state == RUN) && !hazard && slot_free && !illegal;
  assign issue     = dec_valid && dec_ready;
  assign stall     = dec_valid && !dec_ready && (state != TRAP);
  assign trap      = (state == TRAP);

  always_comb begin
    state_d = state;
    flush_d = 1'b0;
    case (state)
      RUN: begin
        if (dec_valid && illegal) begin
          state_d = TRAP;
        end else if (issue && dec_isBranch) begin
          state_d = WAIT_BR;
        end
      end
      WAIT_BR: begin
        if (br_resolved) begin
          state_d = RUN;
          flush_d = br_taken;
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = RUN;
    endcase
  end

  // Clear first so that a set on the same index in the same cycle wins.
  always_comb begin
    sb_d = sb_busy;
    if (ld_done && (ld_rd != 5'd0)) begin
      sb_d[ld_rd] = 1'b0;
    end
    if (issue && dec_isLoad && (dec_rdi != 5'd0)) begin
      sb_d[dec_rdi] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush     <= 1'b0;
      sb_busy   <= 32'd0;
      stall_cnt <= '0;
    end else begin
      state   <= state_d;
      flush   <= flush_d;
      sb_busy <= sb_d;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_rs1i     <= 5'd0;
      ex_rs2i     <= 5'd0;
      ex_rdi      <= 5'd0;
      ex_imm      <= 32'd0;
      ex_code     <= 12'd0;
      ex_isLoad   <= 1'b0;
      ex_isBranch <= 1'b0;
    end else if (issue) begin
      ex_valid    <= 1'b1;
      ex_rs1i     <= dec_rs1i;
      ex_rs2i     <= dec_rs2i;
      ex_rdi      <= dec_rdi;
      ex_imm      <= dec_imm;
      ex_code     <= dec_code;
      ex_isLoad   <= dec_isLoad;
      ex_isBranch <= dec_isBranch;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Sequences decoded instructions from the instruction decoder into the execute stage through a valid/ready handshake.
- Holds a per-register load scoreboard, stalls issue on load-use and WAW hazards, and serialises control flow by blocking issue until each branch/jump resolves.
- Traps on illegal-instruction codes.
- Sits between the decoder outputs (rs1i/rs2i/rdi/imm/code/isLoad/isBranch) and the execute-stage input register.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- dec_valid  in  1  decoder presents an instruction.
- dec_ready  out  1  controller accepts the instruction this cycle.
- dec_rs1i  in  5  source register 1 index.
- dec_rs2i  in  5  source register 2 index.
- dec_rdi  in  5  destination register index.
- dec_imm  in  32  immediate.
- dec_code  in  12  instruction code.
- dec_isLoad  in  1  instruction is a load.
- dec_isBranch  in  1  instruction is a branch or jump.
- ex_valid  out  1  execute-stage register holds an instruction.
- ex_ready  in  1  execute stage consumes the instruction this cycle.
- ex_rs1i, ex_rs2i, ex_rdi  out  5 each  registered copies of the decoder fields.
- ex_imm  out  32  registered immediate.
- ex_code  out  12  registered code.
- ex_isLoad, ex_isBranch  out  1 each  registered flags.
- ld_done  in  1  load writeback completes this cycle.
- ld_rd  in  5  destination register of the completing load.
- br_resolved  in  1  outstanding branch resolved this cycle.
- br_taken  in  1  qualifies br_resolved; branch redirected.
- flush  out  1  one-cycle pulse: discard the decoder/fetch contents.
- trap  out  1  illegal instruction seen; sticky until rst.
- sb_busy  out  32  scoreboard; bit n set = load pending to xn.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (rst=1 at an edge): state RUN, sb_busy=0, ex_valid=0, all ex_* registers 0, flush=0, trap=0, stall_cnt=0.
  - Reset overrides every other input in the same cycle, including mid-branch wait and pending loads.
  - A ld_done arriving after reset for a load issued before reset is ignored; clearing an already-clear bit has no effect.
- Illegal instruction: dec_code == 12'hFFF or dec_code == 12'h001.
- Hazard, evaluated combinationally from registered sb_busy with no same-cycle ld_done bypass. Any of:
  - sb_busy[rs1i] with rs1i != 0;
  - sb_busy[rs2i] with rs2i != 0;
  - sb_busy[rdi] with rdi != 0.
- Output slot free: ex_valid=0 or ex_ready=1.
- dec_ready = (state==RUN) & !hazard & slot free & !illegal(dec_code).
- Issue (dec_valid & dec_ready): the ex_* registers capture the dec_* fields and ex_valid=1 on the next edge.
  - If ex_ready=1 and there is no issue, ex_valid goes to 0.
  - Otherwise ex_* holds stable while ex_valid=1 and ex_ready=0.
- Scoreboard updates:
  - Issue of a load with rdi != 0 sets sb_busy[rdi].
  - ld_done with ld_rd != 0 clears sb_busy[ld_rd].
  - If set and clear hit the same index in one cycle, set wins.
  - Index 0 is never set.
- State machine:
  - RUN, issue with dec_isBranch=1 -> WAIT_BR.
  - RUN, dec_valid=1 with illegal code -> TRAP. The instruction is not consumed; trap=1 from the next cycle.
  - WAIT_BR: dec_ready=0. On br_resolved -> RUN, and flush=1 for exactly that next cycle if br_taken=1.
  - br_resolved while in RUN is ignored.
  - Issue is allowed in the cycle after returning to RUN.
  - TRAP: dec_ready=0, trap=1, flush=0. ex_valid still drains normally via ex_ready; ld_done still clears the scoreboard. Only rst exits TRAP.
- stall_cnt: +1 each cycle with dec_valid=1 & dec_ready=0 in RUN or WAIT_BR. Saturates at all-ones and does not wrap.
- Latency: one cycle from decoder handshake to ex_valid. Throughput is one instruction per cycle with no hazards and ex_ready held at 1.

Test Plan:
- Back-to-back flow: after reset, 4 independent ALU instructions (code 12'h033, distinct rd), ex_ready=1 -> dec_ready=1 every cycle, ex_valid high cycles 1-4, fields match in order, stall_cnt=0.
- Load-use with simultaneous completion: load to x5, then add with rs1i=5 -> dec_ready=0 and stall_cnt increments until ld_done with ld_rd=5. The add issues the cycle after ld_done (no bypass); sb_busy[5] observed 1, then 0.
- Same-index set/clear: ld_done for x7 in the same cycle a new load to x7 issues -> sb_busy[7] remains 1. A load to x0 never sets bit 0.
- Branch wait and flush: issue a branch, hold dec_valid -> dec_ready=0 for 3 cycles. br_resolved=1 with br_taken=1 -> flush=1 for exactly one cycle, then issue resumes. Repeat with br_taken=0 -> flush stays 0.
- Backpressure and illegal instruction: ex_ready=0 with ex_valid=1 -> ex_* stable and dec_ready=0. Then present dec_code=12'hFFF -> not issued, trap=1 sticky, dec_ready=0; rst=1 for one cycle returns all outputs to reset values.
- Stall counter saturation: with CNT_W=4, stall 20 cycles -> stall_cnt=4'hF, no wrap.
